// File: rtl/alu.sv
// rtl/alu.sv - CompactRISC16 ALU with registered result and status flags
//
// Ports:
//   I_CLK    clock, all state updates on the rising edge
//   I_RESET  asynchronous active-high reset, clears O_dest and flags
//   I_op1    operand 1 (Rdest value)
//   I_op2    operand 2 (Rsrc value or immediate)
//   Opcode   operation select
//   O_dest   registered result, one cycle after the operands are sampled
//   flags    registered status {C, L, F, Z, N}

module alu #(
    parameter int WIDTH = 16
) (
    input  logic             I_CLK,
    input  logic             I_RESET,
    input  logic [WIDTH-1:0] I_op1,
    input  logic [WIDTH-1:0] I_op2,
    input  logic [3:0]       Opcode,
    output logic [WIDTH-1:0] O_dest,
    output logic [4:0]       flags
);

    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADDU = 4'h1,
        OP_ADDC = 4'h2,
        OP_SUB  = 4'h3,
        OP_SUBC = 4'h4,
        OP_CMP  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LSH  = 4'hA,
        OP_ASHU = 4'hB,
        OP_MOV  = 4'hC,
        OP_LUI  = 4'hD,
        OP_MUL  = 4'hE,
        OP_RSVD = 4'hF
    } opcode_t;

    // Carry-in comes from the registered flag, so an ADDC/SUBC following
    // a flag-setting op sees the value committed on the previous edge.
    logic             carry_in;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic             add_ovf;
    logic             sub_ovf;

    // Shift amount: op2 is signed; negative means shift right by |op2|.
    logic             shift_right;
    logic [WIDTH-1:0] shift_mag;
    logic             shift_big;
    logic [3:0]       shift_amt;
    logic [WIDTH-1:0] lsh_result;
    logic [WIDTH-1:0] ashu_result;

    logic [WIDTH-1:0] mul_result;
    logic [WIDTH-1:0] next_dest;
    logic [4:0]       next_flags;

    always_comb begin
        carry_in = 1'b0;
        if (Opcode == OP_ADDC || Opcode == OP_SUBC) begin
            carry_in = flags[FLAG_C];
        end
    end

    // 17-bit arithmetic: bit 16 is carry-out for adds and borrow for
    // subtracts (a negative difference wraps with bit 16 set).
    assign add_sum  = {1'b0, I_op1} + {1'b0, I_op2} + {{WIDTH{1'b0}}, carry_in};
    assign sub_diff = {1'b0, I_op1} - {1'b0, I_op2} - {{WIDTH{1'b0}}, carry_in};

    assign add_ovf = (I_op1[WIDTH-1] == I_op2[WIDTH-1]) &&
                     (add_sum[WIDTH-1] != I_op1[WIDTH-1]);
    assign sub_ovf = (I_op1[WIDTH-1] != I_op2[WIDTH-1]) &&
                     (sub_diff[WIDTH-1] != I_op1[WIDTH-1]);

    assign shift_right = I_op2[WIDTH-1];
    assign shift_mag   = shift_right ? (~I_op2 + 1'b1) : I_op2;
    // 0x8000 negates to itself, which still lands in the >=16 bucket.
    assign shift_big   = |shift_mag[WIDTH-1:4];
    assign shift_amt   = shift_mag[3:0];

    always_comb begin
        lsh_result  = '0;
        ashu_result = '0;
        if (!shift_right) begin
            if (!shift_big) begin
                lsh_result  = I_op1 << shift_amt;
                ashu_result = I_op1 << shift_amt;
            end
        end else begin
            if (shift_big) begin
                lsh_result  = '0;
                ashu_result = {WIDTH{I_op1[WIDTH-1]}};
            end else begin
                lsh_result  = I_op1 >> shift_amt;
                ashu_result = WIDTH'($signed(I_op1) >>> shift_amt);
            end
        end
    end

    assign mul_result = I_op1 * I_op2;

    always_comb begin
        next_dest  = '0;
        next_flags = flags;
        case (Opcode)
            OP_ADD, OP_ADDC: begin
                next_dest          = add_sum[WIDTH-1:0];
                next_flags[FLAG_C] = add_sum[WIDTH];
                next_flags[FLAG_F] = add_ovf;
            end
            OP_ADDU: next_dest = add_sum[WIDTH-1:0];
            OP_SUB, OP_SUBC: begin
                next_dest          = sub_diff[WIDTH-1:0];
                next_flags[FLAG_C] = sub_diff[WIDTH];
                next_flags[FLAG_F] = sub_ovf;
            end
            OP_CMP: begin
                next_dest          = sub_diff[WIDTH-1:0];
                next_flags[FLAG_Z] = (I_op1 == I_op2);
                next_flags[FLAG_L] = (I_op1 < I_op2);
                next_flags[FLAG_N] = ($signed(I_op1) < $signed(I_op2));
            end
            OP_AND:  next_dest = I_op1 & I_op2;
            OP_OR:   next_dest = I_op1 | I_op2;
            OP_XOR:  next_dest = I_op1 ^ I_op2;
            OP_NOT:  next_dest = ~I_op1;
            OP_LSH:  next_dest = lsh_result;
            OP_ASHU: next_dest = ashu_result;
            OP_MOV:  next_dest = I_op2;
            OP_LUI:  next_dest = {I_op2[7:0], 8'h00};
            OP_MUL:  next_dest = mul_result;
            default: next_dest = '0;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            O_dest <= '0;
            flags  <= '0;
        end else begin
            O_dest <= next_dest;
            flags  <= next_flags;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for alu

module tb_alu;

    logic        clk;
    logic        rst;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [3:0]  opcode;
    logic [15:0] dest;
    logic [4:0]  flags;

    int checks   = 0;
    int failures = 0;

    alu #(.WIDTH(16)) dut (
        .I_CLK   (clk),
        .I_RESET (rst),
        .I_op1   (op1),
        .I_op2   (op2),
        .Opcode  (opcode),
        .O_dest  (dest),
        .flags   (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply one operation, clock it in, sample just after the edge.
    task automatic step(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        opcode = op;
        op1    = a;
        op2    = b;
        @(posedge clk);
        #1;
    endtask

    // flags layout: {C, L, F, Z, N}
    initial begin
        rst    = 1'b0;
        opcode = 4'h0;
        op1    = 16'h1234;
        op2    = 16'h5678;
        #2;
        rst = 1'b1;
        #1;
        check16("reset_dest", dest, 16'h0000);
        check5 ("reset_flags", flags, 5'b00000);
        @(posedge clk);
        #1;
        rst = 1'b0;

        step(4'h3, 16'h0002, 16'h0003);
        check16("sub_dest", dest, 16'hFFFF);
        check5 ("sub_flags", flags, 5'b10000);

        // SUBC with C=1: 5-2-1
        step(4'h4, 16'h0005, 16'h0002);
        check16("subc_c1_dest", dest, 16'h0002);
        check5 ("subc_c1_flags", flags, 5'b00000);

        step(4'h0, 16'h7FFF, 16'h0001);
        check16("add_ovf_dest", dest, 16'h8000);
        check5 ("add_ovf_flags", flags, 5'b00100);

        step(4'h0, 16'hFFFF, 16'h0001);
        check16("add_carry_dest", dest, 16'h0000);
        check5 ("add_carry_flags", flags, 5'b10000);

        step(4'h2, 16'h0000, 16'h0000);
        check16("addc_dest", dest, 16'h0001);
        check5 ("addc_flags", flags, 5'b00000);

        step(4'h4, 16'h0005, 16'h0002);
        check16("subc_c0_dest", dest, 16'h0003);
        check5 ("subc_c0_flags", flags, 5'b00000);

        // Set C=1 and F=0, then confirm CMP leaves them alone
        step(4'h0, 16'hFFFF, 16'h0001);
        step(4'h5, 16'hFFF1, 16'h000F);
        check16("cmp_neg_dest", dest, 16'hFFE2);
        check5 ("cmp_neg_flags", flags, 5'b10001);

        step(4'h5, 16'h0007, 16'h0007);
        check16("cmp_eq_dest", dest, 16'h0000);
        check5 ("cmp_eq_flags", flags, 5'b10010);

        step(4'h1, 16'hFFFF, 16'h0002);
        check16("addu_dest", dest, 16'h0001);
        check5 ("addu_flags", flags, 5'b10010);

        step(4'hA, 16'h8001, 16'h0001);
        check16("lsh_left", dest, 16'h0002);
        step(4'hA, 16'h8001, 16'hFFFF);
        check16("lsh_right", dest, 16'h4000);
        step(4'hB, 16'h8000, 16'hFFFC);
        check16("ashu_right", dest, 16'hF800);
        step(4'hA, 16'hFFFF, 16'h0010);
        check16("lsh_16", dest, 16'h0000);
        step(4'hA, 16'hFFFF, 16'hFFF0);
        check16("lsh_m16", dest, 16'h0000);
        step(4'hB, 16'h8000, 16'hFFF0);
        check16("ashu_m16", dest, 16'hFFFF);
        step(4'hB, 16'h0003, 16'h0010);
        check16("ashu_16", dest, 16'h0000);
        step(4'hB, 16'h0003, 16'h0002);
        check16("ashu_left", dest, 16'h000C);

        step(4'h6, 16'h00F0, 16'h0FF0);
        check16("and", dest, 16'h00F0);
        step(4'h7, 16'h00F0, 16'h0FF0);
        check16("or", dest, 16'h0FF0);
        step(4'h8, 16'h00F0, 16'h0FF0);
        check16("xor", dest, 16'h0F00);
        step(4'h9, 16'h00F0, 16'h0000);
        check16("not", dest, 16'hFF0F);
        step(4'hC, 16'h1111, 16'hBEEF);
        check16("mov", dest, 16'hBEEF);
        step(4'hD, 16'h0000, 16'h00AB);
        check16("lui", dest, 16'hAB00);
        step(4'hE, 16'h0010, 16'h0011);
        check16("mul", dest, 16'h0110);
        step(4'hE, 16'h1234, 16'h0100);
        check16("mul_trunc", dest, 16'h3400);
        step(4'hF, 16'hFFFF, 16'hFFFF);
        check16("rsvd_dest", dest, 16'h0000);
        check5 ("logic_flags_hold", flags, 5'b10010);

        // Mid-sequence async reset, then first op after release sees C=0
        opcode = 4'h2;
        op1    = 16'h0001;
        op2    = 16'h0001;
        #2;
        rst = 1'b1;
        #1;
        check16("midreset_dest", dest, 16'h0000);
        check5 ("midreset_flags", flags, 5'b00000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(4'h2, 16'h0001, 16'h0001);
        check16("post_reset_addc", dest, 16'h0002);
        check5 ("post_reset_flags", flags, 5'b00000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
